// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full adder stepped over W cycles, LSB first.
// Reports sum, carry-out and signed overflow with a one-cycle done pulse.
module serial_adder_ctrl #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  a_sr_q, a_sr_d;
    logic [W-1:0]  b_sr_q, b_sr_d;
    logic [W-1:0]  sum_q, sum_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          carry_q, carry_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;
    logic          fa_s, fa_cy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        fa_s    = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
        fa_cy   = (a_sr_q[0] & b_sr_q[0])
                | (a_sr_q[0] & carry_q)
                | (b_sr_q[0] & carry_q);
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    a_sr_d  = a;
                    b_sr_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                end
            end
            SHIFT: begin
                sum_d   = {fa_s, sum_q[W-1:1]};
                carry_d = fa_cy;
                a_sr_d  = a_sr_q >> 1;
                b_sr_d  = b_sr_q >> 1;
                // Last bit: carry into MSB vs carry out gives overflow
                if (cnt_q == CW'(W - 1)) begin
                    ovf_d   = carry_q ^ fa_cy;
                    cout_d  = fa_cy;
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule
